// File: rtl/pc_pkg.sv
// Shared constants and reference helpers for the parallel-counter datapath.
package pc_pkg;

  localparam int PC_N  = 7;
  localparam int PC_CW = $clog2(PC_N + 1);

  // Clamp a count to PC_N and expand it to a left-justified thermometer word.
  function automatic logic [PC_N-1:0] therm_encode(input logic [PC_CW-1:0] cnt);
    logic [PC_CW-1:0] c;
    c = (cnt > PC_CW'(PC_N)) ? PC_CW'(PC_N) : cnt;
    return ~({PC_N{1'b1}} >> c);
  endfunction

  // Number of set bits in a word, for checkers sitting beside the datapath.
  function automatic logic [PC_CW-1:0] popcount_ref(input logic [PC_N-1:0] word);
    logic [PC_CW-1:0] acc;
    acc = '0;
    for (int i = 0; i < PC_N; i++) acc = acc + PC_CW'(word[i]);
    return acc;
  endfunction

endpackage

// File: rtl/pc_therm_encoder.sv
// Inverse of the sorting-network counter: clamps a binary count to N and
// expands it into a sorted thermometer word (ones packed at the MSB end).
module pc_therm_encoder
  import pc_pkg::*;
#(
  parameter int N  = PC_N,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [CW-1:0] count,
  output logic [CW-1:0] cnt_c,
  output logic          sat,
  output logic [N-1:0]  therm
);

  localparam logic [N-1:0] ALL_ONES = {N{1'b1}};

  // Clamp, then shift a mask of ones right by the count and invert it.
  always_comb begin
    sat   = (count > CW'(N));
    cnt_c = sat ? CW'(N) : count;
    therm = ~(ALL_ONES >> cnt_c);
  end

endmodule

// File: rtl/pc_unary_pattern_gen.sv
// Unary pattern generator: turns a stream of counts into N-bit words whose
// popcount equals each (clamped) count. Two register stages with a
// valid/ready handshake on both sides; the output word may be rotated by a
// running pointer so the downstream counter also sees unsorted patterns.
module pc_unary_pattern_gen
  import pc_pkg::*;
#(
  parameter int N      = PC_N,
  parameter int CW     = $clog2(N + 1),
  parameter bit ROTATE = 1'b1,
  parameter int TW     = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_count,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_word,
  output logic          out_sat,
  output logic [TW-1:0] total_ones
);

  localparam int            PW      = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0] PTR_MAX = PW'(N - 1);

  logic [CW-1:0]  enc_cnt;
  logic           enc_sat;
  logic [N-1:0]   enc_therm;

  logic           s1_valid;
  logic [CW-1:0]  s1_cnt;
  logic           s1_sat;
  logic [N-1:0]   s1_therm;
  logic [CW-1:0]  s2_cnt;

  logic [PW-1:0]  ptr;
  logic [PW-1:0]  ptr_inc;
  logic [PW-1:0]  ptr_load;

  logic           s2_adv;
  logic           s1_adv;
  logic           out_xfer;
  logic [2*N-1:0] rot_dbl;
  logic [N-1:0]   s2_word;

  pc_therm_encoder #(
    .N  (N),
    .CW (CW)
  ) u_enc (
    .count (in_count),
    .cnt_c (enc_cnt),
    .sat   (enc_sat),
    .therm (enc_therm)
  );

  // Pipeline advance, handshake and rotation of the word entering stage 2.
  // A word loaded in the same cycle as an output transfer sees the already
  // incremented pointer, so each word is rotated by its delivery index.
  always_comb begin
    s2_adv   = !out_valid || out_ready;
    s1_adv   = !s1_valid || s2_adv;
    in_ready = s1_adv && !rst;
    out_xfer = out_valid && out_ready;
    ptr_inc  = (ptr == PTR_MAX) ? '0 : ptr + 1'b1;
    ptr_load = out_xfer ? ptr_inc : ptr;
    rot_dbl  = {s1_therm, s1_therm} << ptr_load;
    s2_word  = ROTATE ? rot_dbl[2*N-1:N] : s1_therm;
  end

  // Stage 1: capture the clamped count and its thermometer on input transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_cnt   <= '0;
      s1_sat   <= 1'b0;
      s1_therm <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_cnt   <= enc_cnt;
        s1_sat   <= enc_sat;
        s1_therm <= enc_therm;
      end
    end
  end

  // Stage 2: output register, holds while the sink stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_word  <= '0;
      out_sat   <= 1'b0;
      s2_cnt    <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_word <= s2_word;
        out_sat  <= s1_sat;
        s2_cnt   <= s1_cnt;
      end
    end
  end

  // Rotation pointer: counts delivered words modulo N.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (out_xfer) begin
      ptr <= ptr_inc;
    end
  end

  // Running total of ones delivered, wrapping modulo 2^TW.
  always_ff @(posedge clk) begin
    if (rst) begin
      total_ones <= '0;
    end else if (out_xfer) begin
      total_ones <= total_ones + TW'(s2_cnt);
    end
  end

endmodule
